oneshot_multi: RTL
==================

# oneshot_multi

Parametrised multi-channel push-button front end: synchronises, debounces and converts each raw button input into a single-cycle pulse, and drives a WIDTH-bit up/down counter from channels 0 (up) and 1 (down). It is the next generation of the team's two-button oneshot counter. It sits between the board buttons and the display/clock-setting logic, replacing fixed-width, non-debounced edge detection.

## Interface
- CH, 2: number of button channels (min 2); ch0 = up, ch1 = down, ch2..CH-1 pulse-only.
- DEB_CYCLES, 4: consecutive stable samples required to accept a press or a release (min 1).
- WIDTH, 4: counter width.
- REPEAT_HOLD, 50: held cycles after the first pulse before auto-repeat starts (used only with ONESHOT_AUTOREPEAT_EN).
- REPEAT_RATE, 10: cycles between repeat pulses (used only with ONESHOT_AUTOREPEAT_EN).

- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ln  in  CH  raw button inputs, active-high, asynchronous to clk.
- pulse  out  CH  one-cycle accepted-press pulses, registered.
- dataout  out  WIDTH  up/down counter value.

## Operation
- Each channel has a 2-flop synchroniser, then a per-channel FSM with a debounce counter of width $clog2(DEB_CYCLES+1).
- FSM states:
  - IDLE: enter PRESS when the synchronised input is 1, with the counter loaded to 1.
  - PRESS: input 1 increments the counter; at DEB_CYCLES, go to HELD and assert pulse[i] for one cycle. Input 0 returns to IDLE with no pulse (glitch rejected).
  - HELD: input 0 enters RELEASE with the counter loaded to 1.
  - RELEASE: input 0 increments the counter; at DEB_CYCLES, go to IDLE. Input 1 returns to HELD with no new pulse.
- At most one pulse per press without the auto-repeat feature. Release bounce never produces a pulse.
- Counter update on each clock, from pulse[0] and pulse[1]:
  - pulse[0] only: dataout + 1.
  - pulse[1] only: dataout - 1.
  - both or neither: no change.
- Arithmetic is modulo 2^WIDTH: increment from all-ones gives 0, decrement from 0 gives all-ones.
- Reset (async assert, any state):
  - all FSMs go to IDLE, debounce/repeat counters and synchronisers clear;
  - pulse = 0, dataout = 0.
- After deassertion, a button already held must complete a full PRESS debounce before pulsing.

## Timing
- Let edge E0 be the first clk edge at which the first synchroniser flop samples ln[i] = 1, with ln[i] stable afterwards.
- pulse[i] is high for exactly the one cycle following edge E0 + DEB_CYCLES + 2.
- dataout updates on the next edge, E0 + DEB_CYCLES + 3. Total press-to-count latency is DEB_CYCLES + 3 cycles.
- A high glitch shorter than DEB_CYCLES synchronised samples produces no pulse.
- Release must be accepted (DEB_CYCLES low samples) before the next press is recognised. Minimum press-to-press period is 2·DEB_CYCLES + 2 cycles.
- Channels are independent; simultaneous presses on different channels pulse on the same cycle.

## Configuration
- ONESHOT_AUTOREPEAT_EN defined:
  - each channel has a repeat counter active in HELD;
  - REPEAT_HOLD cycles after the initial pulse, pulse[i] asserts again, then every REPEAT_RATE cycles while still HELD;
  - entering RELEASE clears the repeat counter, and a return to HELD from RELEASE restarts the REPEAT_HOLD wait;
  - repeat pulses drive dataout like normal pulses.
- ONESHOT_AUTOREPEAT_EN undefined: no repeat logic is synthesised; REPEAT_HOLD and REPEAT_RATE are ignored; exactly one pulse per accepted press.

## Test plan
All scenarios use the defaults (CH=2, DEB_CYCLES=4, WIDTH=4) unless stated.
1. Reset: hold reset=0, toggle ln -> pulse=0, dataout=0 throughout; release reset, ln=0 -> outputs stay 0.
2. Single press: ln[0] high for 20 cycles -> one pulse[0], 6 cycles after first sample; dataout 0->1 at cycle 7; no further change on release.
3. Bounce and glitch:
   - ln[0] high 3 cycles, then low -> no pulse, dataout stays 0.
   - Press with 2-cycle low bounces during release -> exactly one pulse.
4. Wrap-around:
   - 16 ch0 presses from 0 -> dataout returns to 0.
   - One ch1 press from 0 -> dataout = 15.
5. Simultaneous:
   - ln[0] and ln[1] rise on the same cycle -> both pulses, dataout unchanged.
   - Async reset asserted mid-PRESS -> no pulse, dataout = 0.
6. With ONESHOT_AUTOREPEAT_EN, REPEAT_HOLD=20, REPEAT_RATE=5: hold ln[0] for 45 cycles after the first pulse -> pulses at +0, +20, +25, +30, +35, +40; dataout = 6.

Source files
------------

// File: rtl/oneshot_multi.sv
// oneshot_multi: multi-channel push-button front end.
// Each raw button input is synchronised, debounced on both press and release,
// and turned into a one-cycle registered pulse. Channel 0 counts the WIDTH-bit
// counter up and channel 1 counts it down (modulo 2^WIDTH). Higher channels
// only produce pulses.
//
// Optional feature macro: ONESHOT_AUTOREPEAT_EN
//   When defined, a held button re-pulses REPEAT_HOLD cycles after the first
//   pulse and then every REPEAT_RATE cycles until the release is accepted.
//   When undefined, no repeat logic exists and each press pulses exactly once.
//
// Per-channel FSM states:
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | button released and accepted, waiting for a high sample
//   ST_PRESS   | counting consecutive high samples, a low sample aborts
//   ST_HELD    | press accepted (pulse issued), waiting for a low sample
//   ST_RELEASE | counting consecutive low samples, a high sample re-holds

module oneshot_multi #(
    parameter int CH          = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int WIDTH       = 4,
    parameter int REPEAT_HOLD = 50,
    parameter int REPEAT_RATE = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH-1:0]    ln,
    output logic [CH-1:0]    pulse,
    output logic [WIDTH-1:0] dataout
);

    localparam int             DW      = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0]  DEB_MAX = DW'(DEB_CYCLES);
    localparam logic [DW-1:0]  DEB_ONE = DW'(1);

`ifdef ONESHOT_AUTOREPEAT_EN
    localparam int             RPT_MAX   = (REPEAT_HOLD > REPEAT_RATE) ? REPEAT_HOLD : REPEAT_RATE;
    localparam int             RW        = $clog2(RPT_MAX + 1);
    // The repeat counter runs down to zero; the pulse fires on the terminal count.
    localparam logic [RW-1:0]  HOLD_LOAD = RW'(REPEAT_HOLD - 1);
    localparam logic [RW-1:0]  RATE_LOAD = RW'(REPEAT_RATE - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Out-of-range parameters leave this empty marker block in the hierarchy.
    if (CH < 2 || DEB_CYCLES < 1 || REPEAT_HOLD < 1 || REPEAT_RATE < 1) begin : g_bad_params
    end

    logic [CH-1:0]    sync1_q, sync1_d;
    logic [CH-1:0]    sync2_q, sync2_d;
    logic [CH-1:0]    pulse_vec;
    logic [WIDTH-1:0] dataout_q, dataout_d;

    // Two-flop synchroniser input next-state.
    always_comb begin
        sync1_d = ln;
        sync2_d = sync1_q;
    end

    // Synchroniser registers; cleared so a held button must re-debounce after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t          state_q, state_d;
        logic [DW-1:0]   cnt_q, cnt_d;
        logic            pulse_q, pulse_d;
`ifdef ONESHOT_AUTOREPEAT_EN
        logic [RW-1:0]   rpt_q, rpt_d;
`endif

        // Debounce FSM next-state, counter and pulse decode.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
`ifdef ONESHOT_AUTOREPEAT_EN
            rpt_d   = rpt_q;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (sync2_q[i]) begin
                        state_d = ST_PRESS;
                        cnt_d   = DEB_ONE;
                    end
                end
                ST_PRESS: begin
                    if (!sync2_q[i]) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_MAX) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
`ifdef ONESHOT_AUTOREPEAT_EN
                        rpt_d   = HOLD_LOAD;
`endif
                    end else begin
                        cnt_d = cnt_q + DEB_ONE;
                    end
                end
                ST_HELD: begin
                    if (!sync2_q[i]) begin
                        state_d = ST_RELEASE;
                        cnt_d   = DEB_ONE;
`ifdef ONESHOT_AUTOREPEAT_EN
                        rpt_d   = '0;
`endif
                    end
`ifdef ONESHOT_AUTOREPEAT_EN
                    else if (rpt_q == '0) begin
                        pulse_d = 1'b1;
                        rpt_d   = RATE_LOAD;
                    end else begin
                        rpt_d = rpt_q - 1'b1;
                    end
`endif
                end
                ST_RELEASE: begin
                    if (sync2_q[i]) begin
                        // Release bounce: back to held, no new pulse.
                        state_d = ST_HELD;
                        cnt_d   = '0;
`ifdef ONESHOT_AUTOREPEAT_EN
                        rpt_d   = HOLD_LOAD;
`endif
                    end else if (cnt_q == DEB_MAX) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DEB_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Per-channel FSM, debounce counter and registered pulse.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
`ifdef ONESHOT_AUTOREPEAT_EN
                rpt_q   <= '0;
`endif
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
`ifdef ONESHOT_AUTOREPEAT_EN
                rpt_q   <= rpt_d;
`endif
            end
        end

        assign pulse_vec[i] = pulse_q;
    end

    // Up/down counter next value; simultaneous up and down cancel out.
    always_comb begin
        dataout_d = dataout_q;
        case ({pulse_vec[1], pulse_vec[0]})
            2'b01:   dataout_d = dataout_q + 1'b1;
            2'b10:   dataout_d = dataout_q - 1'b1;
            default: dataout_d = dataout_q;
        endcase
    end

    // Counter register, wraps naturally at the WIDTH boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataout_q <= '0;
        end else begin
            dataout_q <= dataout_d;
        end
    end

    assign pulse   = pulse_vec;
    assign dataout = dataout_q;

endmodule
